// File: rtl/imem_loader.sv
// imem_loader: streams words into byte-wide instruction memory, holding the MIPS core in reset until loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require an XOR trailer word after the image.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int BYTE_LANES = 4,
    parameter bit BIG_ENDIAN = 0,
    parameter int MAX_WORDS = (2 ** ADDR_W) / BYTE_LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       len,
    input  logic                    s_valid,
    input  logic [8*BYTE_LANES-1:0] s_data,
    output logic                    s_ready,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [7:0]              mem_wdata,
    output logic                    core_rst,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_W-1:0]       words_loaded
);
    localparam int DW = 8 * BYTE_LANES;
    localparam int LW = BYTE_LANES > 1 ? $clog2(BYTE_LANES) : 1;
    typedef enum logic [2:0] {
        IDLE, WAIT_WORD, WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE, ERR
    } state_t;
    state_t state;
    logic [DW-1:0] data;
    logic [LW-1:0] lane;
    logic [ADDR_W-1:0] len_q;
    logic len_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DW-1:0] csum;
`endif
    assign len_ok = (len != '0) && (32'(len) <= $unsigned(MAX_WORDS));
    function automatic logic [7:0] lane_byte(input logic [DW-1:0] w, input int l);
        logic [DW-1:0] s;
        s = w >> (8 * (BIG_ENDIAN ? BYTE_LANES - 1 - l : l));
        return s[7:0];
    endfunction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            data <= '0;
            lane <= '0;
            len_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= '0;
`endif
            s_ready <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            core_rst <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    core_rst <= 1'b1;
                    done <= 1'b0;
                    if (len_ok) begin
                        state <= WAIT_WORD;
                        len_q <= len;
                        words_loaded <= '0;
                        lane <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= '0;
`endif
                        s_ready <= 1'b1;
                        busy <= 1'b1;
                        err <= 1'b0;
                    end else begin
                        state <= ERR;
                        err <= 1'b1;
                    end
                end
                WAIT_WORD: if (s_valid) begin
                    state <= WRITE;
                    s_ready <= 1'b0;
                    data <= s_data;
                    lane <= '0;
                    mem_we <= 1'b1;
                    mem_addr <= ADDR_W'(words_loaded * BYTE_LANES);
                    mem_wdata <= lane_byte(s_data, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum <= csum ^ s_data;
`endif
                end
                WRITE: if (lane == LW'(BYTE_LANES - 1)) begin
                    mem_we <= 1'b0;
                    words_loaded <= words_loaded + ADDR_W'(1);
                    if (words_loaded + ADDR_W'(1) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= CHECK;
                        s_ready <= 1'b1;
`else
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        core_rst <= 1'b0;
`endif
                    end else begin
                        state <= WAIT_WORD;
                        s_ready <= 1'b1;
                    end
                end else begin
                    lane <= lane + LW'(1);
                    mem_addr <= mem_addr + ADDR_W'(1);
                    mem_wdata <= lane_byte(data, int'(lane) + 1);
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                // Trailer is compared against the running XOR and never written to memory
                CHECK: if (s_valid) begin
                    s_ready <= 1'b0;
                    busy <= 1'b0;
                    if (s_data == csum) begin
                        state <= DONE;
                        done <= 1'b1;
                        core_rst <= 1'b0;
                    end else begin
                        state <= ERR;
                        err <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench driving a little-endian and a big-endian imem_loader.
module tb_imem_loader;
    logic clk = 0, rst = 1, start = 0, start_b = 0, s_valid = 0;
    logic [9:0] len = '0;
    logic [31:0] s_data = '0;
    logic s_ready, mem_we, core_rst, busy, done, err;
    logic [9:0] mem_addr, words_loaded;
    logic [7:0] mem_wdata;
    logic s_ready_b, mem_we_b, core_rst_b, busy_b, done_b, err_b;
    logic [9:0] mem_addr_b, words_loaded_b;
    logic [7:0] mem_wdata_b;
    int checks = 0, errors = 0, cyc = 0;
    logic [17:0] exp_q[$];
    logic [17:0] exp_qb[$];
    logic [31:0] img[3] = '{32'h20420000, 32'h20630001, 32'h00623827};
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int DONE_LAT = 17;
    logic [31:0] tr_flip = '0;
`else
    localparam int DONE_LAT = 16;
`endif

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
    );
    imem_loader #(.BIG_ENDIAN(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .len(len), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .core_rst(core_rst_b), .busy(busy_b), .done(done_b), .err(err_b), .words_loaded(words_loaded_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, want);
        end
    endtask

    always @(negedge clk) if (!rst && mem_we) begin
        if (exp_q.size() == 0) chk("le_stray_write", 32'({mem_addr, mem_wdata}), 32'hffffffff);
        else chk("le_write", 32'({mem_addr, mem_wdata}), 32'(exp_q.pop_front()));
    end

    always @(negedge clk) if (!rst && mem_we_b) begin
        if (exp_qb.size() == 0) chk("be_stray_write", 32'({mem_addr_b, mem_wdata_b}), 32'hffffffff);
        else chk("be_write", 32'({mem_addr_b, mem_wdata_b}), 32'(exp_qb.pop_front()));
    end

    task automatic check_reset();
        chk("rst_core_rst", 32'(core_rst), 1);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_words", 32'(words_loaded), 0);
    endtask

    task automatic send(input bit be, input logic [31:0] w, input int idx, input int gap, input bit push);
        int n = 0;
        if (gap > 0) begin
            s_valid = 0;
            while (!(be ? s_ready_b : s_ready) && n < 50) begin tick(); n++; end
            for (int i = 0; i < gap; i++) begin
                tick();
                chk("gap_s_ready", 32'(s_ready), 1);
                chk("gap_no_write", 32'(mem_we), 0);
            end
        end
        if (push) for (int k = 0; k < 4; k++) begin
            if (be) exp_qb.push_back({10'(idx * 4 + k), w[8 * (3 - k) +: 8]});
            else exp_q.push_back({10'(idx * 4 + k), w[8 * k +: 8]});
        end
        s_data = w;
        s_valid = 1;
        n = 0;
        while (!(be ? s_ready_b : s_ready) && n < 50) begin tick(); n++; end
        chk("handshake_timeout", 32'(n < 50), 1);
        tick();
    endtask

    task automatic load(input bit be, input int n, input int gap, output int took);
        int c0;
        int t = 0;
        len = 10'(n);
        if (be) start_b = 1; else start = 1;
        c0 = cyc;
        tick();
        start = 0;
        start_b = 0;
        chk("start_s_ready", 32'(be ? s_ready_b : s_ready), 1);
        chk("start_busy", 32'(be ? busy_b : busy), 1);
        chk("start_done", 32'(be ? done_b : done), 0);
        chk("start_core_rst", 32'(be ? core_rst_b : core_rst), 1);
        for (int i = 0; i < n; i++) send(be, img[i], i, gap, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [31:0] x = '0;
            for (int i = 0; i < n; i++) x ^= img[i];
            send(be, x ^ tr_flip, 0, 0, 0);
        end
`endif
        s_valid = 0;
        while (!(be ? (done_b | err_b) : (done | err)) && t < 100) begin tick(); t++; end
        chk("done_timeout", 32'(t < 100), 1);
        took = cyc - c0;
    endtask

    initial begin
        int took;
        repeat (3) tick();
        check_reset();
        rst = 0;
        tick();

        load(0, 3, 0, took);
        chk("done_latency", took, DONE_LAT);
        chk("le_done", 32'(done), 1);
        chk("le_core_rst", 32'(core_rst), 0);
        chk("le_words", 32'(words_loaded), 3);
        chk("le_busy", 32'(busy), 0);
        chk("le_err", 32'(err), 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        s_data = 32'hdeadbeef;
        s_valid = 1;
        repeat (3) begin tick(); chk("extra_word_s_ready", 32'(s_ready), 0); end
        s_valid = 0;
`endif

        load(1, 1, 0, took);
        chk("be_done", 32'(done_b), 1);
        chk("be_core_rst", 32'(core_rst_b), 0);
        chk("be_words", 32'(words_loaded_b), 1);
        chk("be_busy", 32'(busy_b), 0);
        chk("be_err", 32'(err_b), 0);
        chk("be_s_ready", 32'(s_ready_b), 0);

        load(0, 3, 5, took);
        chk("bp_done", 32'(done), 1);
        chk("bp_words", 32'(words_loaded), 3);

        len = 0;
        start = 1;
        tick();
        start = 0;
        chk("len0_err", 32'(err), 1);
        chk("len0_core_rst", 32'(core_rst), 1);
        chk("len0_done", 32'(done), 0);
        chk("len0_busy", 32'(busy), 0);
        chk("len0_s_ready", 32'(s_ready), 0);
        len = 10'(257);
        start = 1;
        tick();
        start = 0;
        chk("lenmax_err", 32'(err), 1);
        chk("lenmax_core_rst", 32'(core_rst), 1);
        tick();
        chk("err_level", 32'(err), 1);
        load(0, 1, 0, took);
        chk("recover_done", 32'(done), 1);
        chk("recover_err", 32'(err), 0);
        chk("recover_words", 32'(words_loaded), 1);

        len = 3;
        start = 1;
        tick();
        start = 0;
        send(0, img[0], 0, 0, 1);
        send(0, img[1], 1, 0, 1);
        tick();
        s_valid = 0;
        rst = 1;
        #1;
        check_reset();
        exp_q.delete();
        tick();
        rst = 0;
        tick();
        load(0, 3, 0, took);
        chk("reload_done", 32'(done), 1);
        chk("reload_words", 32'(words_loaded), 3);

`ifdef IMEM_LOADER_CHECKSUM_EN
        tr_flip = 32'h1;
        load(0, 3, 0, took);
        chk("bad_trailer_err", 32'(err), 1);
        chk("bad_trailer_core_rst", 32'(core_rst), 1);
        chk("bad_trailer_done", 32'(done), 0);
        tr_flip = '0;
        load(0, 3, 0, took);
        chk("good_trailer_done", 32'(done), 1);
`endif

        chk("le_scoreboard_drain", exp_q.size(), 0);
        chk("be_scoreboard_drain", exp_qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
